issuequeue_div: RTL
===================

// Module: issuequeue_div
// PURPOSE
//  Divide-unit reservation station, directly upstream of the divider issue stage.
//  Holds up to DEPTH dispatched divide ops and captures pending operands from CDB broadcasts.
//  Issues the oldest fully-ready op to the divider when it is not busy.
//  Drives issuediv_enable/rsdata/rtdata/rdtag from registers.
// PARAMETERS
//  DEPTH      4   queue entries (2..8); index 0 is always the oldest
//  DATA_W     16  operand width (dividend/divisor)
//  TAG_W      6   ROB/physical tag width
//  HOLDOFF    2   cycles after an issue during which no new issue occurs (covers divider busy latency)
// PORTS
//  clk               in   1       clock, rising edge
//  reset             in   1       asynchronous, active-high
//  flush             in   1       sync: discard all entries (branch mispredict)
//  dispatch_en       in   1       write one op this cycle
//  dispatch_rsdata   in   DATA_W  dividend value (valid if dispatch_rsvalid)
//  dispatch_rsvalid  in   1       dividend ready
//  dispatch_rstag    in   TAG_W   dividend producer tag
//  dispatch_rtdata   in   DATA_W  divisor value
//  dispatch_rtvalid  in   1       divisor ready
//  dispatch_rttag    in   TAG_W   divisor producer tag
//  dispatch_rdtag    in   TAG_W   destination tag
//  iq_full           out  1       count==DEPTH; upstream must not dispatch
//  cdb_valid         in   1       CDB broadcast valid
//  cdb_tag           in   TAG_W   broadcast tag
//  cdb_data          in   DATA_W  broadcast value
//  issuediv_busy     in   1       divider not accepting
//  issuediv_enable   out  1       registered one-cycle issue pulse
//  issuediv_rsdata   out  DATA_W  issued dividend (registered)
//  issuediv_rtdata   out  DATA_W  issued divisor (registered)
//  issuediv_rdtag    out  TAG_W   issued destination tag (registered)
// BEHAVIOUR
//  - Reset: all entries invalid; count=0; holdoff=0; every output 0.
//  - Entry: {valid, rsdata, rsvalid, rstag, rtdata, rtvalid, rttag, rdtag}. Ready = valid & rsvalid & rtvalid.
//  - Wakeup: each cycle, cdb_valid & operand !valid & tag==cdb_tag -> capture cdb_data, set valid.
//  - Dispatch bypass: a dispatched operand arriving !valid whose tag equals the same-cycle CDB tag is written valid with cdb_data.
//  - Dispatch accepted iff dispatch_en & !iq_full & !flush; an op dispatched while full is dropped, state unchanged.
//  - Issue condition: !issuediv_busy & holdoff==0 & some entry ready.
//    Select the lowest ready index; load the output regs; issuediv_enable=1 next cycle only.
//    Load holdoff=HOLDOFF; holdoff decrements to 0.
//  - Latency: an entry that is ready at cycle N (including ready via CDB wakeup at edge N) drives enable high at cycle N+1.
//    An op dispatched fully ready at edge N becomes eligible in cycle N+1.
//  - Collapse: entries above the issued index shift down one in the same edge.
//    A same-cycle dispatch is written at index count-issued. count_next = count + accepted - issued.
//  - Simultaneous issue + dispatch at count==DEPTH: the dispatch is dropped (iq_full is based on current count).
//  - Non-issue cycles: enable=0; data/tag outputs hold their last value.
//  - Flush: at the next edge, all entries are invalid, count=0, holdoff=0, enable=0. A flush overrides dispatch and issue in the same cycle.
//  - Async reset mid-operation: immediate return to reset state; no pending issue survives.
// CONFIGURATION
//  ISSUEQUEUE_DIV_DIVZERO_EN defined:
//   - Adds ports divz_valid (out, 1) and divz_rdtag (out, TAG_W), both registered and reset to 0.
//   - A selected ready entry with rtdata==0 does not pulse issuediv_enable; it pulses divz_valid with its rdtag instead.
//   - That entry ignores issuediv_busy and holdoff, is removed and collapsed as for a normal issue, and leaves holdoff unchanged.
//  Macro undefined: the divz ports are absent; divisor-0 ops issue to the divider like any other.
// TESTING
//  1. Reset, dispatch rs=100 rt=7 rd=5, both valid, busy=0 -> enable=1 two cycles after dispatch, rs=100 rt=7 rdtag=5, for one cycle.
//  2. Dispatch rt pending tag 9, rd=3; CDB tag 9 data 4 three cycles later -> enable next cycle with rt=4, rdtag=3.
//  3. Dispatch with rt pending tag 12 while CDB carries tag 12 data 8 in the same cycle -> captured, issue with rt=8 (bypass).
//  4. Fill 4 ops with busy=1 -> iq_full=1; 5th dispatch dropped. Release busy -> issue order rd 1,2,3,4; enable pulses spaced >=HOLDOFF+1 cycles.
//  5. Entries rd=1 (not ready) and rd=2 (ready) -> rd=2 issues first; rd=1 collapses to index 0.
//     Then flush -> iq_full=0, no further enable.
//  6. DIVZERO_EN: dispatch rt=0 rd=6 while busy=1 -> divz_valid=1 with divz_rdtag=6, enable stays 0.
//     Assert reset mid-queue -> all outputs 0 immediately.

Source files
------------

// File: rtl/issuequeue_div_if.sv
// Dispatch / CDB / issue bundle for the divide reservation station.
// The divide-by-zero report lines exist only when ISSUEQUEUE_DIV_DIVZERO_EN is defined.
interface issuequeue_div_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6
);
  logic              flush;
  logic              dispatch_en;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic              dispatch_rsvalid;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic              iq_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issuediv_busy;
  logic              issuediv_enable;
  logic [DATA_W-1:0] issuediv_rsdata;
  logic [DATA_W-1:0] issuediv_rtdata;
  logic [TAG_W-1:0]  issuediv_rdtag;
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
  logic              divz_valid;
  logic [TAG_W-1:0]  divz_rdtag;
`endif

  modport master (
    output flush, dispatch_en, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
           dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issuediv_busy,
    input  iq_full, issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
    , input divz_valid, divz_rdtag
`endif
  );

  modport slave (
    input  flush, dispatch_en, dispatch_rsdata, dispatch_rsvalid, dispatch_rstag,
           dispatch_rtdata, dispatch_rtvalid, dispatch_rttag, dispatch_rdtag,
           cdb_valid, cdb_tag, cdb_data, issuediv_busy,
    output iq_full, issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
    , output divz_valid, divz_rdtag
`endif
  );
endinterface

// File: rtl/issuequeue_div.sv
// Divide-unit reservation station: collapsing queue (index 0 oldest), CDB wakeup, oldest-ready issue.
// Define ISSUEQUEUE_DIV_DIVZERO_EN to divert divisor-zero ops to the divz_valid/divz_rdtag report.
module issuequeue_div #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 6,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             reset,
  issuequeue_div_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rsdata;
    logic              rsvalid;
    logic [TAG_W-1:0]  rstag;
    logic [DATA_W-1:0] rtdata;
    logic              rtvalid;
    logic [TAG_W-1:0]  rttag;
    logic [TAG_W-1:0]  rdtag;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d, wk;
  entry_t             disp;
  logic [CW-1:0]      count_q, count_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [DEPTH-1:0]   rdy;
  logic [IW-1:0]      sel;
  logic               any_rdy, divz, iss_go, removed, accept;
  logic               en_q;
  logic [DATA_W-1:0]  rs_q, rt_q;
  logic [TAG_W-1:0]   rd_q;
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
  logic               dz_q;
  logic [TAG_W-1:0]   dztag_q;
`endif

  function automatic entry_t wake(entry_t e, logic v, logic [TAG_W-1:0] t, logic [DATA_W-1:0] d);
    wake = e;
    if (v && !e.rsvalid && e.rstag == t) begin
      wake.rsvalid = 1'b1;
      wake.rsdata  = d;
    end
    if (v && !e.rtvalid && e.rttag == t) begin
      wake.rtvalid = 1'b1;
      wake.rtdata  = d;
    end
  endfunction

  assign bus.iq_full         = (count_q == CW'(DEPTH));
  assign bus.issuediv_enable = en_q;
  assign bus.issuediv_rsdata = rs_q;
  assign bus.issuediv_rtdata = rt_q;
  assign bus.issuediv_rdtag  = rd_q;
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
  assign bus.divz_valid = dz_q;
  assign bus.divz_rdtag = dztag_q;
`endif

  always_comb begin
    // Selection sees registered readiness only; a CDB hit this cycle issues next cycle.
    rdy     = '0;
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].valid && ent_q[i].rsvalid && ent_q[i].rtvalid;
      wk[i]  = ent_q[i].valid ? wake(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data) : ent_q[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel     = IW'(i);
        any_rdy = 1'b1;
      end
    end
`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
    divz = any_rdy && (ent_q[sel].rtdata == '0) && !bus.flush;
`else
    divz = 1'b0;
`endif
    iss_go  = any_rdy && !divz && !bus.issuediv_busy && (hold_q == '0) && !bus.flush;
    removed = iss_go || divz;
    accept  = bus.dispatch_en && !bus.iq_full && !bus.flush;

    disp = wake('{valid: 1'b1, rsdata: bus.dispatch_rsdata, rsvalid: bus.dispatch_rsvalid,
                  rstag: bus.dispatch_rstag, rtdata: bus.dispatch_rtdata,
                  rtvalid: bus.dispatch_rtvalid, rttag: bus.dispatch_rttag,
                  rdtag: bus.dispatch_rdtag},
                bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

    ent_d = wk;
    if (removed) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= int'(sel)) ent_d[i] = wk[i+1];
      ent_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (accept && i == int'(count_q) - int'(removed)) ent_d[i] = disp;
    count_d = count_q + CW'(accept) - CW'(removed);

    if (iss_go)              hold_d = HW'(HOLDOFF);
    else if (hold_q != '0)   hold_d = hold_q - 1'b1;
    else                     hold_d = '0;

    if (bus.flush) begin
      ent_d   = '0;
      count_d = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      count_q <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      en_q    <= iss_go;
      if (iss_go) begin
        rs_q <= ent_q[sel].rsdata;
        rt_q <= ent_q[sel].rtdata;
        rd_q <= ent_q[sel].rdtag;
      end
    end
  end

`ifdef ISSUEQUEUE_DIV_DIVZERO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_q    <= 1'b0;
      dztag_q <= '0;
    end else begin
      dz_q <= divz;
      if (divz) dztag_q <= ent_q[sel].rdtag;
    end
  end
`endif
endmodule
